// File: rtl/seed_collector.sv
// Samples a decimated random stream into a ChaCha20 key and nonce, skipping all-zero words,
// and offers the finished seed over valid/ready. Define SEED_HEALTH_CHECK_EN to add a repetition test.
module seed_collector #(
    parameter int N           = 32,
    parameter int KEY_WORDS   = 8,
    parameter int NONCE_WORDS = 3,
    parameter int SKIP        = 3,
    parameter int REP_LIMIT   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N-1:0]               rnd_in,
    input  logic                       req,
    output logic                       busy,
    output logic [N*KEY_WORDS-1:0]     key_out,
    output logic [N*NONCE_WORDS-1:0]   nonce_out,
    output logic                       seed_valid,
    input  logic                       seed_ready,
    output logic                       err
);

    localparam int W  = KEY_WORDS + NONCE_WORDS;
    localparam int IW = (W > 1) ? $clog2(W) : 1;
    localparam int DW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;

    if (KEY_WORDS < 1 || NONCE_WORDS < 1 || SKIP < 0 || REP_LIMIT < 2) begin : g_param_check
        $error("seed_collector: illegal parameter set");
    end

`ifdef SEED_HEALTH_CHECK_EN
    typedef enum logic [1:0] {IDLE, COLLECT, HOLD, FAIL} state_t;
`else
    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;
`endif

    state_t                   state_q, next_state;
    logic [DW-1:0]            dec_q;
    logic [IW-1:0]            widx_q;
    logic [N*KEY_WORDS-1:0]   key_q;
    logic [N*NONCE_WORDS-1:0] nonce_q;
    logic                     take, keep, last_word, start, rep_fail;

    assign start     = (state_q == IDLE) && req;
    assign take      = (state_q == COLLECT) && (dec_q == DW'(SKIP));
    assign keep      = take && (rnd_in != '0);
    assign last_word = (widx_q == IW'(W - 1));

`ifdef SEED_HEALTH_CHECK_EN
    localparam int RW = $clog2(REP_LIMIT + 1);

    logic [N-1:0]  last_q;
    logic [RW-1:0] rep_q, rep_next;

    // A run length of zero means no sample has been seen since COLLECT was entered.
    always_comb begin
        rep_next = ((rep_q != '0) && (rnd_in == last_q)) ? rep_q + 1'b1 : RW'(1);
        rep_fail = take && (rep_next == RW'(REP_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_q  <= '0;
            last_q <= '0;
        end else if (start) begin
            rep_q  <= '0;
        end else if (take) begin
            rep_q  <= rep_next;
            last_q <= rnd_in;
        end
    end

    assign err = (state_q == FAIL);
`else
    assign rep_fail = 1'b0;
    assign err      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= next_state;
    end

    // NOTE: next_state gets its default before the case, so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state_q;
        case (state_q)
            IDLE:    if (req) next_state = COLLECT;
            COLLECT: begin
`ifdef SEED_HEALTH_CHECK_EN
                if (rep_fail)               next_state = FAIL;
                else
`endif
                if (keep && last_word)      next_state = HOLD;
            end
            HOLD:    if (seed_ready) next_state = IDLE;
`ifdef SEED_HEALTH_CHECK_EN
            FAIL:    next_state = FAIL;
`endif
            default: next_state = IDLE;
        endcase
    end

    // NOTE: the seed buffers are reset as well, because key_out/nonce_out must read 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_q   <= '0;
            widx_q  <= '0;
            key_q   <= '0;
            nonce_q <= '0;
        end else if (start) begin
            dec_q  <= '0;
            widx_q <= '0;
        end else if (state_q == COLLECT) begin
            dec_q <= take ? '0 : dec_q + 1'b1;
            if (keep) begin
                widx_q <= widx_q + 1'b1;
                for (int k = 0; k < KEY_WORDS; k++)
                    if (widx_q == IW'(k)) key_q[N*k +: N] <= rnd_in;
                for (int j = 0; j < NONCE_WORDS; j++)
                    if (widx_q == IW'(KEY_WORDS + j)) nonce_q[N*j +: N] <= rnd_in;
            end
        end
    end

    assign busy       = (state_q != IDLE);
    assign seed_valid = (state_q == HOLD);
    assign key_out    = key_q;
    assign nonce_out  = nonce_q;

endmodule

// File: tb/tb_seed_collector.sv
// Directed self-checking bench for seed_collector at default parameters.
// Cycle numbers count clock edges after the cycle in which req is presented.
module tb_seed_collector;

    localparam int N  = 32;
    localparam int KW = 8;
    localparam int NW = 3;

    logic              clk = 1'b0;
    logic              rst, req, seed_ready;
    logic [N-1:0]      rnd_in;
    logic              busy, seed_valid, err;
    logic [N*KW-1:0]   key_out;
    logic [N*NW-1:0]   nonce_out;

    int cyc, mode;
    int passed = 0, failed = 0, total = 0;

    seed_collector dut (
        .clk        (clk),
        .rst        (rst),
        .rnd_in     (rnd_in),
        .req        (req),
        .busy       (busy),
        .key_out    (key_out),
        .nonce_out  (nonce_out),
        .seed_valid (seed_valid),
        .seed_ready (seed_ready),
        .err        (err)
    );

    always #5 clk = ~clk;

    // mode 0: cycle number; mode 1: zero before cycle 10, then cycle number; mode 2: constant 5
    task automatic set_rnd();
        case (mode)
            0:       rnd_in = N'(cyc);
            1:       rnd_in = (cyc < 10) ? '0 : N'(cyc);
            default: rnd_in = 32'h5;
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        set_rnd();
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*KW-1:0] key_exp(input int base, input int stride);
        logic [N*KW-1:0] r;
        for (int k = 0; k < KW; k++) r[N*k +: N] = N'(base + stride * k);
        return r;
    endfunction

    function automatic logic [N*NW-1:0] nonce_exp(input int base, input int stride);
        logic [N*NW-1:0] r;
        for (int j = 0; j < NW; j++) r[N*j +: N] = N'(base + stride * j);
        return r;
    endfunction

    task automatic start_req();
        cyc = 0;
        set_rnd();
        req = 1'b1;
        step();
        req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; seed_ready = 1'b0; mode = 0; cyc = 0; rnd_in = '0;
        step(); step();
        check("rst_valid", seed_valid, 1'b0);
        check("rst_busy",  busy, 1'b0);
        check("rst_err",   err, 1'b0);
        check("rst_key",   key_out, '0);
        check("rst_nonce", nonce_out, '0);
        rst = 1'b0;
        step();
        check("idle_busy", busy, 1'b0);

        // Run A: rnd_in = cycle number, stray req in cycle 10
        mode = 0;
        start_req();
        while (cyc < 45) begin
            check("a_busy",  busy, 1'b1);
            check("a_valid", seed_valid, 1'b0);
            if (cyc == 10) req = 1'b1;
            step();
            req = 1'b0;
        end
        check("a_valid45", seed_valid, 1'b1);
        check("a_busy45",  busy, 1'b1);
        check("a_key",     key_out, key_exp(4, 4));
        check("a_nonce",   nonce_out, nonce_exp(36, 4));

        // Hold without ready for 20 cycles, stray req in cycle 46
        for (int i = 0; i < 20; i++) begin
            if (cyc == 46) req = 1'b1;
            step();
            req = 1'b0;
            check("hold_valid", seed_valid, 1'b1);
            check("hold_key",   key_out, key_exp(4, 4));
            check("hold_nonce", nonce_out, nonce_exp(36, 4));
        end
        // Handshake with a coinciding req, which must not restart collection
        seed_ready = 1'b1; req = 1'b1;
        step();
        seed_ready = 1'b0; req = 1'b0;
        check("xfer_valid", seed_valid, 1'b0);
        check("xfer_busy",  busy, 1'b0);
        check("xfer_key",   key_out, key_exp(4, 4));
        check("xfer_nonce", nonce_out, nonce_exp(36, 4));
        seed_ready = 1'b1;
        step(); step();
        seed_ready = 1'b0;
        check("idle_after_busy",  busy, 1'b0);
        check("idle_after_valid", seed_valid, 1'b0);

        // Run B: zero words in cycles 0-9 are rejected
        mode = 1;
        start_req();
        run_to(52);
        check("b_valid52", seed_valid, 1'b0);
        step();
        check("b_valid53", seed_valid, 1'b1);
        check("b_key0",    key_out[N-1:0], 32'd12);
        check("b_nlast",   nonce_out[N*NW-1 -: N], 32'd52);
        check("b_key",     key_out, key_exp(12, 4));
        check("b_nonce",   nonce_out, nonce_exp(44, 4));
        seed_ready = 1'b1;
        step();
        seed_ready = 1'b0;
        check("b_xfer", seed_valid, 1'b0);

        // Run C: reset in cycle 20, then a fresh collection
        mode = 0;
        start_req();
        run_to(20);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("c_rst_key",   key_out, '0);
        check("c_rst_nonce", nonce_out, '0);
        check("c_rst_valid", seed_valid, 1'b0);
        check("c_rst_busy",  busy, 1'b0);
        check("c_rst_err",   err, 1'b0);
        start_req();
        run_to(44);
        check("c_valid44", seed_valid, 1'b0);
        step();
        check("c_valid45", seed_valid, 1'b1);
        check("c_key",     key_out, key_exp(4, 4));
        check("c_nonce",   nonce_out, nonce_exp(36, 4));
        seed_ready = 1'b1;
        step();
        seed_ready = 1'b0;
        check("c_xfer", busy, 1'b0);

        // Run D: constant rnd_in = 5
        mode = 2;
        start_req();
`ifdef SEED_HEALTH_CHECK_EN
        run_to(16);
        check("d_err16",  err, 1'b0);
        step();
        check("d_err17",  err, 1'b1);
        check("d_busy17", busy, 1'b1);
        seed_ready = 1'b1;
        while (cyc < 60) begin
            if (cyc == 30) req = 1'b1;
            step();
            req = 1'b0;
            check("d_valid", seed_valid, 1'b0);
        end
        seed_ready = 1'b0;
        check("d_err60",  err, 1'b1);
        check("d_busy60", busy, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("d_rst_err",  err, 1'b0);
        check("d_rst_busy", busy, 1'b0);
`else
        while (cyc < 45) begin
            check("d_err", err, 1'b0);
            step();
        end
        check("d_valid45", seed_valid, 1'b1);
        check("d_key",     key_out, key_exp(5, 0));
        check("d_nonce",   nonce_out, nonce_exp(5, 0));
        seed_ready = 1'b1;
        step();
        seed_ready = 1'b0;
        check("d_xfer", seed_valid, 1'b0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seed_collector.md
Name: seed_collector

Overview:
Consumer-side companion to the LFSR random seed generator. Samples the free-running N-bit random stream on request and assembles a ChaCha20 key of KEY_WORDS words and a nonce of NONCE_WORDS words. Decimates the stream and rejects all-zero words. Presents the completed seed to the cipher core through a valid/ready handshake.

Parameters:
N, 32, random word width in bits
KEY_WORDS, 8, number of key words (256-bit key at N=32)
NONCE_WORDS, 3, number of nonce words (96-bit nonce at N=32)
SKIP, 3, sample one word every SKIP+1 cycles
REP_LIMIT, 4, consecutive-identical-sample limit; used only by the optional feature

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
rnd_in  in  N  random word from the seed generator, may change every cycle
req  in  1  start a collection; honoured only in IDLE
busy  out  1  high in COLLECT and HOLD (and FAIL)
key_out  out  N*KEY_WORDS  assembled key; word k at [N*k +: N]
nonce_out  out  N*NONCE_WORDS  assembled nonce; word j at [N*j +: N]
seed_valid  out  1  key_out and nonce_out complete and stable
seed_ready  in  1  consumer accepts the seed
err  out  1  health-test failure, sticky

Behaviour:
- Reset (rst=1 at a clock edge):
  - state IDLE; key_out, nonce_out, seed_valid, busy and err all 0.
  - Clears the decimation counter, word index and repetition counter.
  - rst overrides every other input, including mid-COLLECT and HOLD.
- States: IDLE, COLLECT, HOLD, plus FAIL (macro only).
- IDLE:
  - On req=1, go to COLLECT next cycle and clear decimation counter and word index to 0.
  - Buffers are not cleared on entry to COLLECT; previous seed contents are overwritten word by word.
- COLLECT:
  - Decimation counter increments each cycle. A sample is taken in the cycle the counter equals SKIP, then the counter returns to 0.
  - Nonzero sample: stored at word index k, then k increments. For k<KEY_WORDS it goes to key word k, otherwise to nonce word k-KEY_WORDS.
  - Zero sample: discarded, k unchanged, decimation continues normally.
  - After word KEY_WORDS+NONCE_WORDS-1 is stored, go to HOLD; seed_valid=1 from the next cycle.
- Latency: with req in cycle 0 and no rejected words, samples are taken in cycles (SKIP+1)*i for i=1..W, where W=KEY_WORDS+NONCE_WORDS. seed_valid rises in cycle W*(SKIP+1)+1, which is cycle 45 at defaults.
- HOLD:
  - key_out and nonce_out are frozen and seed_valid stays high.
  - When seed_valid and seed_ready are both high at an edge, the transfer completes: seed_valid=0 and state IDLE next cycle, busy=0.
  - Data outputs retain their values after the transfer.
- req outside IDLE is ignored, including a req coinciding with the HOLD handshake; it must be reissued in IDLE.
- seed_ready outside HOLD is ignored.
- Width rules: word index is clog2(W) bits and the decimation counter is clog2(SKIP+1) bits, minimum 1 bit each. No arithmetic is performed on the data.

Optional Feature:
- Macro SEED_HEALTH_CHECK_EN.
- Defined:
  - A repetition test runs on every sampled word, zeros included.
  - When REP_LIMIT consecutive samples are equal, the state becomes FAIL and err=1 on the following cycle.
  - FAIL: seed_valid=0, busy=1, req ignored, buffers frozen. Exit only via rst.
  - The repetition counter resets on entry to COLLECT.
- Undefined:
  - No FAIL state and no repetition counter.
  - err is tied to 0.
  - REP_LIMIT is unused.

Test Plan:
- rst, then req in cycle 0 with rnd_in = cycle number (defaults) -> key words 4,8,...,32; nonce words 36,40,44; seed_valid=1 in cycle 45; busy=1 in cycles 1-45.
- Hold seed_ready=0 for 20 cycles after seed_valid -> outputs and seed_valid unchanged; pulse seed_ready=1 -> seed_valid=0 and busy=0 next cycle; key_out and nonce_out retained.
- rnd_in=0 in cycles 0-9, then cycle number -> samples in cycles 4 and 8 discarded; key word0=12; last nonce word=52; seed_valid in cycle 53.
- req pulses in cycles 10 and 46 (seed_ready held 0) -> ignored. rst in cycle 20 of a new collection -> all outputs 0 next cycle; next req produces a fresh seed with the standard 45-cycle latency.
- SEED_HEALTH_CHECK_EN defined, rnd_in=32'h5 constant -> samples in cycles 4,8,12,16; err=1 and state FAIL in cycle 17; seed_valid never asserts; req ignored until rst.
- Same stimulus with macro undefined -> err=0; seed_valid in cycle 45; all 11 words equal 32'h5.
